// File: rtl/keypad_scanner.sv
// keypad_scanner: column-driven matrix keypad scanner with per-frame debounce
// and a valid/ready event port. Define KEYPAD_GHOST_EN for ghost-frame rejection.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [COLS-1:0]              column_pins,
    input  logic [ROWS-1:0]              row_pins,
    output logic [ROWS*COLS-1:0]         keys,
    output logic                         event_valid,
    input  logic                         event_ready,
    output logic [$clog2(ROWS*COLS)-1:0] event_code,
    output logic                         event_press,
    output logic                         ghost
);
    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(COLS);
    localparam int BW = $clog2(DEBOUNCE + 1);

    localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]   COL_LAST = IW'(COLS - 1);
    localparam logic [BW-1:0]   DEB_LAST = BW'(DEBOUNCE - 1);
    localparam logic [COLS-1:0] COL_RST  = ~COLS'(1);

    logic [ROWS-1:0]        sync1_q, sync2_q;
    logic [DW-1:0]          div_q, div_d;
    logic [IW-1:0]          col_q, col_d;
    logic [COLS-1:0]        col_pins_q, col_pins_d;
    logic [N-1:0]           raw_q, raw_d;
    logic                   fend_q, fend_d;
    logic [N-1:0]           keys_q, keys_d;
    logic [N-1:0][BW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]           pend_q, pend_d;
    logic [N-1:0]           flip;
    logic                   ev_valid_q, ev_valid_d;
    logic [CW-1:0]          ev_code_q, ev_code_d;
    logic                   ev_press_q, ev_press_d;
    logic                   amb;
    logic                   load;
    logic                   found;
    logic [CW-1:0]          idx;

    // Column dwell counter, rotation and raw-frame capture.
    always_comb begin
        div_d      = div_q + 1'b1;
        col_d      = col_q;
        col_pins_d = col_pins_q;
        raw_d      = raw_q;
        fend_d     = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            for (int r = 0; r < ROWS; r++) begin
                raw_d[r*COLS + int'(col_q)] = ~sync2_q[r];
            end
            col_pins_d = {col_pins_q[COLS-2:0], col_pins_q[COLS-1]};
            if (col_q == COL_LAST) begin
                col_d  = '0;
                fend_d = 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

`ifdef KEYPAD_GHOST_EN
    logic ghost_q, ghost_d;
    int   common;

    // Two rows sharing two pressed columns cannot be told apart from ghosting.
    always_comb begin
        amb    = 1'b0;
        common = 0;
        for (int a = 0; a < ROWS; a++) begin
            for (int b = a + 1; b < ROWS; b++) begin
                common = 0;
                for (int c = 0; c < COLS; c++) begin
                    if (raw_q[a*COLS+c] && raw_q[b*COLS+c]) begin
                        common = common + 1;
                    end
                end
                if (common >= 2) begin
                    amb = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ghost_d = ghost_q;
        if (fend_q) begin
            ghost_d = amb;
        end
    end

    assign ghost = ghost_q;
`else
    assign amb   = 1'b0;
    assign ghost = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        flip  = '0;
        if (fend_q && !amb) begin
            for (int k = 0; k < N; k++) begin
                if (raw_q[k] != keys_q[k]) begin
                    if (cnt_q[k] == DEB_LAST) begin
                        flip[k]  = 1'b1;
                        cnt_d[k] = '0;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end else begin
                    cnt_d[k] = '0;
                end
            end
        end
        keys_d = keys_q ^ flip;
    end

    // Lowest pending index wins; the loader clear lands before the new toggle.
    always_comb begin
        load  = !ev_valid_q || event_ready;
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pend_q[k]) begin
                found = 1'b1;
                idx   = CW'(k);
            end
        end
        pend_d     = pend_q;
        ev_valid_d = ev_valid_q;
        ev_code_d  = ev_code_q;
        ev_press_d = ev_press_q;
        if (load) begin
            ev_valid_d = found;
            if (found) begin
                ev_code_d   = idx;
                ev_press_d  = keys_q[idx];
                pend_d[idx] = 1'b0;
            end
        end
        pend_d = pend_d ^ flip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            div_q      <= '0;
            col_q      <= '0;
            col_pins_q <= COL_RST;
            raw_q      <= '0;
            fend_q     <= 1'b0;
            keys_q     <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_code_q  <= '0;
            ev_press_q <= 1'b0;
`ifdef KEYPAD_GHOST_EN
            ghost_q    <= 1'b0;
`endif
        end else begin
            sync1_q    <= row_pins;
            sync2_q    <= sync1_q;
            div_q      <= div_d;
            col_q      <= col_d;
            col_pins_q <= col_pins_d;
            raw_q      <= raw_d;
            fend_q     <= fend_d;
            keys_q     <= keys_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            ev_press_q <= ev_press_d;
`ifdef KEYPAD_GHOST_EN
            ghost_q    <= ghost_d;
`endif
        end
    end

    assign column_pins = col_pins_q;
    assign keys        = keys_q;
    assign event_valid = ev_valid_q;
    assign event_code  = ev_code_q;
    assign event_press = ev_press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: ideal keypad matrix driven from the column outputs,
// frame-level debounce model and event scoreboard.
module tb_keypad_scanner;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int SD = 4;
    localparam int DB = 4;
    localparam int N  = R * C;
    localparam int FRAME = SD * C;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [C-1:0]  column_pins;
    logic [R-1:0]  row_pins;
    logic [N-1:0]  keys;
    logic          event_valid;
    logic          event_ready;
    logic [3:0]    event_code;
    logic          event_press;
    logic          ghost;

    keypad_scanner #(
        .ROWS(R), .COLS(C), .SCAN_DIV(SD), .DEBOUNCE(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .column_pins(column_pins),
        .row_pins(row_pins), .keys(keys), .event_valid(event_valid),
        .event_ready(event_ready), .event_code(event_code),
        .event_press(event_press), .ghost(ghost)
    );

    always #5 clk = ~clk;

    logic [N-1:0] phys;
    int           ncmp = 0;
    int           nerr = 0;
    int           ncyc = 0;

    // Physical matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_pins = '1;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                if (!column_pins[c] && phys[r*C+c]) row_pins[r] = 1'b0;
            end
        end
    end

    logic [4:0] got[$];
    logic [4:0] expq[$];
    logic [N-1:0] mkeys;
    int           mcnt[N];
    logic         mghost;

    always @(negedge clk) begin
        if (rst_n && event_valid && event_ready) got.push_back({event_code, event_press});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [C-1:0] ecol;
        @(posedge clk);
        #1;
        ncyc++;
        ecol = ~(C'(1) << ((ncyc / SD) % C));
        check("column", 32'(column_pins), 32'(ecol));
    endtask

    task automatic model_reset();
        mkeys  = '0;
        mghost = 1'b0;
        for (int k = 0; k < N; k++) mcnt[k] = 0;
        expq.delete();
        got.delete();
    endtask

    // One whole scanned frame of constant key state.
    task automatic model_frame(input logic [N-1:0] raw);
        bit amb;
        int common;
        amb = 1'b0;
`ifdef KEYPAD_GHOST_EN
        for (int a = 0; a < R; a++) begin
            for (int b = a + 1; b < R; b++) begin
                common = 0;
                for (int c = 0; c < C; c++) if (raw[a*C+c] && raw[b*C+c]) common++;
                if (common >= 2) amb = 1'b1;
            end
        end
`endif
        common = 0;
        mghost = amb;
        if (!amb) begin
            for (int k = 0; k < N; k++) begin
                if (raw[k] != mkeys[k]) begin
                    mcnt[k]++;
                    if (mcnt[k] == DB) begin
                        mkeys[k] = ~mkeys[k];
                        mcnt[k]  = 0;
                        expq.push_back({4'(k), mkeys[k]});
                    end
                end else begin
                    mcnt[k] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] nxt);
        logic [4:0] g;
        do tick(); while (ncyc % FRAME != 0);
        check("keys", 32'(keys), 32'(mkeys));
        check("ghost", 32'(ghost), 32'(mghost));
        while (got.size() > 0) begin
            g = got.pop_front();
            if (expq.size() > 0) check("event", 32'(g), 32'(expq.pop_front()));
            else check("event_unexpected", 32'(g), 32'hffff_ffff);
        end
        model_frame(phys);
        phys = nxt;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] nxt;
        int           ki;
        rst_n       = 1'b0;
        event_ready = 1'b1;
        phys        = '0;
        model_reset();
        #12;
        check("rst_column", 32'(column_pins), 32'hE);
        check("rst_keys", 32'(keys), 0);
        check("rst_valid", 32'(event_valid), 0);
        check("rst_ghost", 32'(ghost), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ncyc  = 0;

        // idle frames: column rotation only
        repeat (2) step('0);

        // key 9 clean press and release
        repeat (4) step(N'(1) << 9);
        tick();
        check("k9_before", 32'(keys[9]), 0);
        step(N'(1) << 9);
        tick();
        check("k9_pressed", 32'(keys[9]), 1);
        repeat (6) step('0);
        check("k9_released", 32'(keys[9]), 0);

        // three-frame bounce
        repeat (3) step(N'(1) << 9);
        repeat (6) step('0);
        check("bounce_keys", 32'(keys), 0);

        // backpressure with keys 0 and 5
        event_ready = 1'b0;
        repeat (5) step(N'(1) | (N'(1) << 5));
        repeat (3) tick();
        check("bp_valid", 32'(event_valid), 1);
        check("bp_code", 32'(event_code), 0);
        check("bp_press", 32'(event_press), 1);
        repeat (4) tick();
        check("bp_hold_valid", 32'(event_valid), 1);
        check("bp_hold_code", 32'(event_code), 0);
        event_ready = 1'b1;
        tick();
        check("bp_second_valid", 32'(event_valid), 1);
        check("bp_second_code", 32'(event_code), 5);
        tick();
        check("bp_drained", 32'(event_valid), 0);
        step(N'(1) | (N'(1) << 5));
        repeat (6) step('0);

        // ghost pattern: keys 0,1,4,5
        repeat (5) step(N'(16'h0033));
        tick();
`ifdef KEYPAD_GHOST_EN
        check("ghost_flag", 32'(ghost), 1);
        check("ghost_keys", 32'(keys), 0);
`else
        check("noghost_keys", 32'(keys), 32'h0033);
`endif
        repeat (6) step('0);

        // randomized key activity
        for (int s = 0; s < 40; s++) begin
            nxt = phys;
            if ($urandom_range(0, 1) == 1) begin
                ki = int'($urandom_range(0, N - 1));
                nxt[ki] = ~nxt[ki];
            end
            if ($urandom_range(0, 3) == 0) begin
                ki = int'($urandom_range(0, N - 1));
                nxt[ki] = ~nxt[ki];
            end
            step(nxt);
        end
        repeat (7) step('0);

        // reset during a held event
        event_ready = 1'b0;
        repeat (5) step(N'(1) << 9);
        repeat (3) tick();
        check("pre_rst_valid", 32'(event_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_column", 32'(column_pins), 32'hE);
        check("mid_rst_keys", 32'(keys), 0);
        check("mid_rst_valid", 32'(event_valid), 0);
        check("mid_rst_code", 32'(event_code), 0);
        check("mid_rst_press", 32'(event_press), 0);
        check("mid_rst_ghost", 32'(ghost), 0);
        phys = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        event_ready = 1'b1;
        rst_n = 1'b1;
        ncyc  = 0;
        repeat (3) step('0);

        check("events_missing", 32'(expq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
